// File: rtl/mult_digit_sequencer.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one 2x2 combinational
// multiplier cell, with valid/ready handshakes on both the operand and result sides.

module multiplier (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] P
);
  assign P = {2'b00, A} * {2'b00, B};
endmodule

module mult_digit_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int N  = WIDTH / DIGIT;
  localparam int PW = 2 * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  generate
    if (DIGIT != 2) begin : g_bad_digit
      $error("mult_digit_sequencer: DIGIT must be 2 to match the multiplier cell");
    end
    if (WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("mult_digit_sequencer: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PW-1:0]     acc;
  logic [IW-1:0]     i;
  logic [IW-1:0]     j;

  logic [1:0]        dig_a;
  logic [1:0]        dig_b;
  logic [3:0]        prod;
  logic [IW:0]       ij_sum;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     sum;

  assign dig_a = a_q[DIGIT*i +: DIGIT];
  assign dig_b = b_q[DIGIT*j +: DIGIT];

  multiplier u_mult (
    .A(dig_a),
    .B(dig_b),
    .P(prod)
  );

  // Digit pair (i,j) carries weight 2^(DIGIT*(i+j)) in the final product.
  assign ij_sum = {1'b0, i} + {1'b0, j};
  assign pp     = PW'(prod) << (DIGIT * ij_sum);
  assign sum    = acc + pp;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      p        <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              p     <= sum;
              state <= DONE;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            if (op_count != 16'hFFFF) begin
              op_count <= op_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_digit_sequencer.sv
// Directed and randomized checks of mult_digit_sequencer against a plain a*b
// reference with handshake, latency, back-pressure and reset behaviour.

module tb_mult_digit_sequencer;

  localparam int WIDTH   = 8;
  localparam int LATENCY = (WIDTH / 2) * (WIDTH / 2);

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  logic [15:0]        op_count;

  int checks;
  int errors;
  int exp_count;
  int cyc;

  mult_digit_sequencer #(.WIDTH(WIDTH), .DIGIT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Wait (bounded) until the block is ready to accept operands.
  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, " ready_wait"}, 32'(in_ready), 32'd1);
  endtask

  // One full operation: accept, measure latency, hold for `stall` cycles, then handshake.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input int stall, input string tag);
    int lat;
    int expp;
    expp = int'(av) * int'(bv);
    waitReady(tag);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(LATENCY));
    checkOutput({tag, " p"}, 32'(p), 32'(expp));
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      tick();
      checkOutput({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " hold_p"}, 32'(p), 32'(expp));
      checkOutput({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (exp_count < 65535) exp_count++;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " op_count"}, 32'(op_count), 32'(exp_count));
    checkOutput({tag, " p_held_idle"}, 32'(p), 32'(expp));
  endtask

  typedef struct {
    logic [7:0] av;
    logic [7:0] bv;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   last_acc;
    int   acc_cyc;
    int   n;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    checks    = 0;
    errors    = 0;
    exp_count = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    repeat (2) tick();
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset p", 32'(p), 32'd0);
    checkOutput("reset op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus(8'd255, 8'd255, 0, "max");
    applyStimulus(8'd0, 8'd200, 0, "zero_a");
    applyStimulus(8'd173, 8'd1, 0, "one_b");
    applyStimulus(8'd17, 8'd240, 5, "backpressure");

    // Back-to-back small operands with in_valid and out_ready held high.
    vecs.push_back('{8'd2, 8'd2});
    vecs.push_back('{8'd3, 8'd1});
    vecs.push_back('{8'd3, 8'd3});
    vecs.push_back('{8'd2, 8'd3});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = -1;
    foreach (vecs[k]) begin
      waitReady("b2b");
      a = vecs[k].av;
      b = vecs[k].bv;
      acc_cyc = cyc;
      if (last_acc >= 0) checkOutput("b2b spacing", 32'(acc_cyc - last_acc), 32'(LATENCY + 2));
      last_acc = acc_cyc;
      tick();
      n = 0;
      while (!out_valid && n < 60) begin
        tick();
        n++;
      end
      checkOutput("b2b p", 32'(p), 32'(int'(vecs[k].av) * int'(vecs[k].bv)));
      if (exp_count < 65535) exp_count++;
      tick();
      checkOutput("b2b op_count", 32'(op_count), 32'(exp_count));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Operands offered during RUN are ignored until the block returns to IDLE.
    waitReady("ignore");
    a = 8'd100;
    b = 8'd50;
    in_valid = 1'b1;
    tick();
    a = 8'd7;
    b = 8'd7;
    n = 0;
    while (!out_valid && n < 60) begin
      checkOutput("ignore in_ready_run", 32'(in_ready), 32'd0);
      tick();
      n++;
    end
    checkOutput("ignore first p", 32'(p), 32'd5000);
    out_ready = 1'b1;
    if (exp_count < 65535) exp_count++;
    tick();
    checkOutput("ignore in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    checkOutput("ignore second latency", 32'(n), 32'(LATENCY));
    checkOutput("ignore second p", 32'(p), 32'd49);
    if (exp_count < 65535) exp_count++;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checkOutput("ignore op_count", 32'(op_count), 32'(exp_count));

    // Randomized operands against the arithmetic reference.
    for (int k = 0; k < 12; k++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), "random");
    end

    // Asynchronous reset in the middle of RUN discards the operation.
    waitReady("midreset");
    a = 8'd201;
    b = 8'd99;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset p", 32'(p), 32'd0);
    checkOutput("midreset op_count", 32'(op_count), 32'd0);
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(8'd12, 8'd12, 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
